// File: rtl/misao_alu_pkg.sv
// misao_alu_pkg
// Shared types and constants for the digit-serial MISA-O ALU.
//   alu_op_t     : 4-bit operation codes (codes 10..15 are reserved).
//   alu_state_t  : controller states IDLE / RUN / DONE.
//   LEN_*        : len encodings for the MISA-O register widths.
//   is_msb_first : true for operations that walk digits from the top down.
package misao_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_INC = 4'd2,
        OP_DEC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_INV = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    localparam int LEN_UL   = 0;
    localparam int LEN_LK8  = 1;
    localparam int LEN_LK16 = 3;

    function automatic logic is_msb_first(input logic [3:0] op);
        return op == OP_SHR;
    endfunction

endpackage

// File: rtl/misao_alu_digit.sv
// misao_alu_digit
// Combinational single-digit slice of the serial ALU.
// Ports:
//   op_i  : operation code (alu_op_t encoding, reserved codes pass a through)
//   a_i   : ACC-side digit
//   b_i   : RS0-side digit
//   c_i   : carry-in / borrow-in / shift-in bit from the previous digit
//   y_o   : result digit
//   c_o   : carry / borrow / shift-out bit to the next digit
// Logic and reserved ops pass c_i straight to c_o so the latched carry flag
// survives the whole operation and becomes cout.
module misao_alu_digit
    import misao_alu_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [3:0]         op_i,
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               c_i,
    output logic [DIGIT_W-1:0] y_o,
    output logic               c_o
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W:0]   diff;

    always_comb begin
        // INC/DEC are ADD/SUB with a zero operand; the +/-1 arrives as c_i.
        b_eff = (op_i == OP_INC || op_i == OP_DEC) ? '0 : b_i;
        sum   = {1'b0, a_i} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, c_i};
        // Top bit of the extended difference is the borrow out.
        diff  = {1'b0, a_i} - {1'b0, b_eff} - {{DIGIT_W{1'b0}}, c_i};
        y_o   = a_i;
        c_o   = c_i;
        case (op_i)
            OP_ADD, OP_INC: begin
                y_o = sum[DIGIT_W-1:0];
                c_o = sum[DIGIT_W];
            end
            OP_SUB, OP_DEC: begin
                y_o = diff[DIGIT_W-1:0];
                c_o = diff[DIGIT_W];
            end
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_XOR: y_o = a_i ^ b_i;
            OP_INV: y_o = ~a_i;
            OP_SHL: begin
                y_o = {a_i[DIGIT_W-2:0], c_i};
                c_o = a_i[DIGIT_W-1];
            end
            OP_SHR: begin
                y_o = {c_i, a_i[DIGIT_W-1:1]};
                c_o = a_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/misao_alu_serial.sv
// misao_alu_serial
// Digit-serial multi-precision ALU for the MISA-O core. Operands are latched
// on an accepted start, one DIGIT_W-bit digit is processed per clock with the
// carry chained through c_q, and done pulses one cycle after the last digit.
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   start         : request, accepted in IDLE or DONE only
//   op, len       : operation code, active digits minus one
//   a, b          : ACC and RS0 operands
//   cin, cen      : carry flag in, carry enable for ADD/SUB
//   busy, done    : operation in progress, one-cycle completion pulse
//   result, cout  : result (zero above the active width), carry/borrow flag
//   zero          : only with MISAO_ALU_ZERO_EN defined; active-width result
//                   is zero, registered alongside result
module misao_alu_serial
    import misao_alu_pkg::*;
#(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int LEN_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [3:0]                     op,
    input  logic [LEN_W-1:0]               len,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]  a,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]  b,
    input  logic                           cin,
    input  logic                           cen,
    output logic                           busy,
    output logic                           done,
    output logic [DIGIT_W*NUM_DIGITS-1:0]  result,
`ifdef MISAO_ALU_ZERO_EN
    output logic                           zero,
`endif
    output logic                           cout
);

    localparam int DATA_W = DIGIT_W * NUM_DIGITS;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NUM_DIGITS - 1);

    alu_state_t          state_q;
    logic [3:0]          op_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                c_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   result_q;
    logic                cout_q;
`ifdef MISAO_ALU_ZERO_EN
    logic                zero_q;
`endif

    logic [LEN_W-1:0]    len_c;
    logic                c_init;
    logic [LEN_W-1:0]    idx;
    logic [DIGIT_W-1:0]  a_dig;
    logic [DIGIT_W-1:0]  b_dig;
    logic [DIGIT_W-1:0]  dig_y;
    logic                dig_c;
    logic [DATA_W-1:0]   result_d;

    // Ones over the active digits; used to drop operand bits above the width.
    function automatic logic [DATA_W-1:0] act_mask(input logic [LEN_W-1:0] l);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (d <= int'(l)) m[d*DIGIT_W +: DIGIT_W] = '1;
        end
        return m;
    endfunction

    always_comb begin
        len_c = (len > LEN_MAX) ? LEN_MAX : len;
        case (op)
            OP_ADD, OP_SUB: c_init = cin & cen;
            OP_INC, OP_DEC: c_init = 1'b1;   // the +/-1 enters as the first carry
            OP_SHL, OP_SHR: c_init = 1'b0;   // zero shifted into the vacated bit
            default:        c_init = cin;    // carried through untouched to cout
        endcase
    end

    // Digit select: SHR walks from the top active digit down.
    always_comb begin
        idx   = is_msb_first(op_q) ? (len_q - cnt_q) : cnt_q;
        a_dig = '0;
        b_dig = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == LEN_W'(d)) begin
                a_dig = a_q[d*DIGIT_W +: DIGIT_W];
                b_dig = b_q[d*DIGIT_W +: DIGIT_W];
            end
        end
    end

    misao_alu_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .op_i (op_q),
        .a_i  (a_dig),
        .b_i  (b_dig),
        .c_i  (c_q),
        .y_o  (dig_y),
        .c_o  (dig_c)
    );

    always_comb begin
        result_d = result_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == LEN_W'(d)) result_d[d*DIGIT_W +: DIGIT_W] = dig_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef MISAO_ALU_ZERO_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q  <= ST_RUN;
                        op_q     <= op;
                        len_q    <= len_c;
                        cnt_q    <= '0;
                        a_q      <= a & act_mask(len_c);
                        b_q      <= b & act_mask(len_c);
                        c_q      <= c_init;
                        busy_q   <= 1'b1;
                        result_q <= '0;
                        cout_q   <= 1'b0;
`ifdef MISAO_ALU_ZERO_EN
                        zero_q   <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    result_q <= result_d;
                    c_q      <= dig_c;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == len_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= dig_c;
`ifdef MISAO_ALU_ZERO_EN
                        zero_q  <= (result_d == '0);
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef MISAO_ALU_ZERO_EN
    assign zero   = zero_q;
`endif

endmodule
